// File: rtl/vx_clone_wspawn_ctrl.sv
// Clone / wspawn register-copy controller.
// Freezes fetch/decode, waits for the pipeline to drain, then streams
// registers 1..31 through the register-file copy port, one beat per
// accepted handshake. Invalid targets skip straight to a DONE+err pulse.
module vx_clone_wspawn_ctrl #(
  parameter int NT         = 4,
  parameter int NW         = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_clone_req,
  input  logic [31:0]           in_clone_tid,
  input  logic                  in_wspawn_req,
  input  logic [31:0]           in_wspawn_wid,
  input  logic                  in_copy_ready,
  output logic                  out_stall,
  output logic                  out_busy,
  output logic                  out_copy_valid,
  output logic                  out_copy_kind,
  output logic [4:0]            out_copy_reg,
  output logic [$clog2(NT)-1:0] out_copy_tid,
  output logic [$clog2(NW)-1:0] out_copy_wid,
  output logic                  out_done,
  output logic                  out_err
);

  localparam int TW = $clog2(NT);
  localparam int WW = $clog2(NW);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COPY   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] settle_cnt;
  logic [4:0]    copy_reg;
  logic          kind;
  logic [TW-1:0] tid;
  logic [WW-1:0] wid;
  logic          err;
  logic          last_wspawn;  // kind of the most recent grant (1 = wspawn)

  logic          any_req;
  logic          pick_wspawn;
  logic [31:0]   tgt;
  logic          tgt_bad;

  // Arbitration and target validation for the request seen in IDLE
  always_comb begin
    any_req     = in_clone_req | in_wspawn_req;
    // On a tie, alternate away from whatever was granted last
    pick_wspawn = in_wspawn_req & (~in_clone_req | ~last_wspawn);
    tgt         = pick_wspawn ? in_wspawn_wid : in_clone_tid;
    tgt_bad     = (tgt == 32'd0) |
                  (pick_wspawn ? (tgt >= 32'(NW)) : (tgt >= 32'(NT)));
  end

  // Control FSM: grant, settle countdown, copy beats, completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      copy_reg    <= '0;
      kind        <= 1'b0;
      tid         <= '0;
      wid         <= '0;
      err         <= 1'b0;
      last_wspawn <= 1'b1;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          kind        <= pick_wspawn;
          last_wspawn <= pick_wspawn;
          // The unused target field reads 0 so consumers need not mask it
          tid         <= pick_wspawn ? '0 : in_clone_tid[TW-1:0];
          wid         <= pick_wspawn ? in_wspawn_wid[WW-1:0] : '0;
          err         <= tgt_bad;
          settle_cnt  <= CW'(SETTLE_CYC - 1);
          state       <= tgt_bad ? DONE : SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state    <= COPY;
            copy_reg <= 5'd1;  // r0 is hardwired zero, never copied
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        COPY: if (in_copy_ready) begin
          if (copy_reg == 5'd31) state <= DONE;
          else                   copy_reg <= copy_reg + 5'd1;
        end
        DONE: begin
          // Requests here belong to the retiring instruction; ignore them
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are masked by reset so nothing leaks before the first edge
  always_comb begin
    out_stall      = ~reset & (((state == IDLE) & any_req) |
                               (state == SETTLE) | (state == COPY));
    out_busy       = ~reset & (state != IDLE);
    out_copy_valid = ~reset & (state == COPY);
    out_done       = ~reset & (state == DONE);
    out_err        = ~reset & (state == DONE) & err;
    out_copy_kind  = ~reset & kind;
    out_copy_reg   = reset ? '0 : copy_reg;
    out_copy_tid   = reset ? '0 : tid;
    out_copy_wid   = reset ? '0 : wid;
  end

endmodule
